car_drive: RTL and testbench
============================

CAR_DRIVE -- requirements
Module: car_drive

Interface
REQ-001 Parameter NUM_FLOORS, default 3, number of served floors (2..3, floors numbered 1..NUM_FLOORS).
REQ-002 Parameter START_DELAY, default 2, cycles a motion command must be stable before the car moves (1..15).
REQ-003 Parameter TRAVEL_CYCLES, default 8, cycles of motion per floor-to-floor trip (1..255).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 elevator_direction  input  2  motion command from the elevator controller: 00 stop, 01 up, 10 down, 11 illegal.
REQ-007 door_open  input  1  door state from the controller; 1 = open.
REQ-008 elevator_arrived  output  1  one-cycle pulse when the car reaches a floor; drives the controller's elevator_arrived.
REQ-009 current_floor  output  2  registered car position, binary 1..NUM_FLOORS.
REQ-010 moving  output  1  high while the car is between floors.
REQ-011 limit_err  output  1  one-cycle pulse on a command past the top or bottom floor.
REQ-012 fault  output  1  sticky safety fault flag.

Function
REQ-013 FSM states: IDLE, START, MOVE, ARRIVE, FAULT; all outputs registered.
REQ-014 IDLE: direction 11 -> FAULT; door_open=1 with any command -> stay IDLE; 01 below top or 10 above floor 1 -> START, latch command, load start counter; 01 at top or 10 at floor 1 -> stay IDLE, limit_err=1 next cycle; 00 -> stay IDLE.
REQ-015 START: command must equal the latched command and door_open=0 for START_DELAY consecutive cycles; any mismatch or door_open=1 -> IDLE, no floor change; 11 -> FAULT.
REQ-016 START completion -> MOVE, load travel counter with TRAVEL_CYCLES-1, moving=1.
REQ-017 MOVE: counter decrements each cycle; at zero -> ARRIVE, current_floor +1 (up) or -1 (down), elevator_arrived=1 on the same edge.
REQ-018 MOVE: direction changes (00, reversal) are ignored; the trip always completes to the adjacent floor.
REQ-019 MOVE: door_open=1 or direction 11 -> FAULT on the next edge; current_floor unchanged.
REQ-020 ARRIVE lasts exactly one cycle, then IDLE; a held command re-enters START, so back-to-back trips incur START_DELAY again.
REQ-021 Latency: command first sampled in IDLE at edge E0 -> elevator_arrived high after edge E0+START_DELAY+TRAVEL_CYCLES (10 cycles at defaults); moving high for exactly TRAVEL_CYCLES cycles.
REQ-022 FAULT: fault=1, moving=0, elevator_arrived=0, limit_err=0; exit only by rst.
REQ-023 current_floor never leaves 1..NUM_FLOORS; wrap-around is impossible by construction.
REQ-024 elevator_arrived and limit_err are never high in the same cycle.

Reset
REQ-025 rst has priority over all events, including mid-MOVE; the next state is IDLE.
REQ-026 Reset values: current_floor=1, elevator_arrived=0, moving=0, limit_err=0, fault=0, counters=0.

Structure
REQ-027 Shared package elevator_pkg holds DIR_STOP/DIR_UP/DIR_DOWN/DIR_ILLEGAL encodings, floor width, and the FSM state type; car_drive and the controller both import it.
REQ-028 One sub-module, travel_timer: loadable down-counter with a zero flag, used for both the start and the travel count.

Verification (defaults)
REQ-029 After reset, hold 01 from floor 1 -> elevator_arrived pulses once 10 cycles after first sample, current_floor=2, moving high 8 cycles.
REQ-030 Hold 01 continuously -> arrivals at floor 2 then floor 3, 11 cycles apart (ARRIVE cycle plus START_DELAY plus TRAVEL_CYCLES); continued 01 at floor 3 -> one limit_err pulse, state stays IDLE.
REQ-031 01 for one cycle, then 00 -> no moving, no arrival, current_floor stays 1.
REQ-032 door_open=1 at MOVE cycle 4 -> fault=1 next cycle and stays set, moving=0; rst -> fault=0, current_floor=1.
REQ-033 From floor 2, drive 10 then switch to 01 at MOVE cycle 3 -> car still arrives at floor 1; direction 11 in IDLE -> fault.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator controller and the car drive:
// motion commands, floor width and the car-drive state type.
package elevator_pkg;

  localparam int FLOOR_W = 2;
  localparam int TIMER_W = 8;

  localparam logic [1:0] DIR_STOP    = 2'b00;
  localparam logic [1:0] DIR_UP      = 2'b01;
  localparam logic [1:0] DIR_DOWN    = 2'b10;
  localparam logic [1:0] DIR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_MOVE,
    ST_ARRIVE,
    ST_FAULT
  } car_state_t;

endpackage

// File: rtl/travel_timer.sv
// Loadable down-counter with a zero flag; reused for the start-stability
// count and the floor-to-floor travel count.
module travel_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/car_drive.sv
// Car drive: turns the controller's motion command into timed floor-to-floor
// trips, with limit reporting and a sticky safety fault.
module car_drive
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 3,
  parameter int START_DELAY   = 2,
  parameter int TRAVEL_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         elevator_direction,
  input  logic               door_open,
  output logic               elevator_arrived,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               moving,
  output logic               limit_err,
  output logic               fault
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS);
  localparam logic [TIMER_W-1:0] START_LOAD  = TIMER_W'(START_DELAY - 1);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);

  car_state_t         state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               limit_hold_q, limit_hold_d;
  logic               arrived_q, arrived_d;
  logic               limit_q, limit_d;
  logic               moving_q, moving_d;
  logic               fault_q, fault_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic               tmr_zero;

  logic cmd_up, cmd_down, at_top, at_bottom;

  assign cmd_up    = (elevator_direction == DIR_UP);
  assign cmd_down  = (elevator_direction == DIR_DOWN);
  assign at_top    = (floor_q == TOP_FLOOR);
  assign at_bottom = (floor_q == FLOOR_W'(1));

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    floor_d      = floor_q;
    limit_hold_d = 1'b0;
    arrived_d    = 1'b0;
    limit_d      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;

    case (state_q)
      // ARRIVE decides like IDLE so a held command restarts without a gap cycle.
      ST_IDLE, ST_ARRIVE: begin
        state_d = ST_IDLE;
        if (elevator_direction == DIR_ILLEGAL) begin
          state_d = ST_FAULT;
        end else if (door_open) begin
          state_d = ST_IDLE;
        end else if ((cmd_up && !at_top) || (cmd_down && !at_bottom)) begin
          state_d      = ST_START;
          dir_d        = elevator_direction;
          tmr_load     = 1'b1;
          tmr_load_val = START_LOAD;
        end else if ((cmd_up && at_top) || (cmd_down && at_bottom)) begin
          // One pulse per held blocked command, not one per cycle.
          limit_d      = !limit_hold_q;
          limit_hold_d = 1'b1;
        end
      end
      ST_START: begin
        if (elevator_direction == DIR_ILLEGAL) begin
          state_d = ST_FAULT;
        end else if (door_open || (elevator_direction != dir_q)) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d      = ST_MOVE;
          tmr_load     = 1'b1;
          tmr_load_val = TRAVEL_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_MOVE: begin
        if (door_open || (elevator_direction == DIR_ILLEGAL)) begin
          state_d = ST_FAULT;
        end else if (tmr_zero) begin
          state_d   = ST_ARRIVE;
          arrived_d = 1'b1;
          floor_d   = (dir_q == DIR_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    moving_d = (state_d == ST_MOVE);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_STOP;
      floor_q      <= FLOOR_W'(1);
      limit_hold_q <= 1'b0;
      arrived_q    <= 1'b0;
      limit_q      <= 1'b0;
      moving_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      floor_q      <= floor_d;
      limit_hold_q <= limit_hold_d;
      arrived_q    <= arrived_d;
      limit_q      <= limit_d;
      moving_q     <= moving_d;
      fault_q      <= fault_d;
    end
  end

  travel_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign elevator_arrived = arrived_q;
  assign current_floor    = floor_q;
  assign moving           = moving_q;
  assign limit_err        = limit_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_car_drive.sv
// Directed bench for car_drive at default parameters: single trip, back-to-back
// trips with top limit, aborted start, bottom limit, door fault, reversal in MOVE.
module tb_car_drive;

  logic       clk;
  logic       rst;
  logic [1:0] elevator_direction;
  logic       door_open;
  logic       elevator_arrived;
  logic [1:0] current_floor;
  logic       moving;
  logic       limit_err;
  logic       fault;

  int checks;
  int errors;

  car_drive dut (
    .clk                (clk),
    .rst                (rst),
    .elevator_direction (elevator_direction),
    .door_open          (door_open),
    .elevator_arrived   (elevator_arrived),
    .current_floor      (current_floor),
    .moving             (moving),
    .limit_err          (limit_err),
    .fault              (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    elevator_direction = 2'b00;
    door_open = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (current_floor !== 2'd1) begin errors++; $display("FAIL reset_floor got %0d exp 1", current_floor); end
    checks++; if (elevator_arrived !== 1'b0) begin errors++; $display("FAIL reset_arrived got %b exp 0", elevator_arrived); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %b exp 0", moving); end
    checks++; if (limit_err !== 1'b0) begin errors++; $display("FAIL reset_limit got %b exp 0", limit_err); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
    $display("test_reset done");
  endtask

  // Hold UP from floor 1: arrival after edge 11 (E0 + 10), moving on edges 3..10.
  task automatic test_single_trip();
    int mcount;
    logic exp_arr, exp_mov;
    do_reset();
    mcount = 0;
    elevator_direction = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      step();
      exp_arr = (k == 11);
      exp_mov = (k >= 3 && k <= 10);
      if (moving === 1'b1) mcount++;
      checks++; if (elevator_arrived !== exp_arr) begin errors++; $display("FAIL trip_arrived k=%0d got %b exp %b", k, elevator_arrived, exp_arr); end
      checks++; if (moving !== exp_mov) begin errors++; $display("FAIL trip_moving k=%0d got %b exp %b", k, moving, exp_mov); end
    end
    elevator_direction = 2'b00;
    step();
    checks++; if (mcount != 8) begin errors++; $display("FAIL trip_moving_cycles got %0d exp 8", mcount); end
    checks++; if (current_floor !== 2'd2) begin errors++; $display("FAIL trip_floor got %0d exp 2", current_floor); end
    checks++; if (elevator_arrived !== 1'b0) begin errors++; $display("FAIL trip_arrived_once got %b exp 0", elevator_arrived); end
    $display("test_single_trip done floor=%0d", current_floor);
  endtask

  // Held UP: arrivals at edges 11 and 22, a single limit pulse at edge 23.
  task automatic test_back_to_back();
    logic exp_arr, exp_lim;
    do_reset();
    elevator_direction = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_arr = (k == 11) || (k == 22);
      exp_lim = (k == 23);
      checks++; if (elevator_arrived !== exp_arr) begin errors++; $display("FAIL b2b_arrived k=%0d got %b exp %b", k, elevator_arrived, exp_arr); end
      checks++; if (limit_err !== exp_lim) begin errors++; $display("FAIL b2b_limit k=%0d got %b exp %b", k, limit_err, exp_lim); end
      if (k == 11) begin
        checks++; if (current_floor !== 2'd2) begin errors++; $display("FAIL b2b_floor2 got %0d exp 2", current_floor); end
      end
    end
    checks++; if (current_floor !== 2'd3) begin errors++; $display("FAIL b2b_floor3 got %0d exp 3", current_floor); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL b2b_idle_moving got %b exp 0", moving); end
    elevator_direction = 2'b00;
    step();
    $display("test_back_to_back done floor=%0d", current_floor);
  endtask

  // UP for a single cycle then STOP: the start is abandoned.
  task automatic test_short_command();
    do_reset();
    elevator_direction = 2'b01;
    step();
    elevator_direction = 2'b00;
    for (int k = 2; k <= 14; k++) begin
      step();
      checks++; if (moving !== 1'b0) begin errors++; $display("FAIL short_moving k=%0d got %b exp 0", k, moving); end
      checks++; if (elevator_arrived !== 1'b0) begin errors++; $display("FAIL short_arrived k=%0d got %b exp 0", k, elevator_arrived); end
    end
    checks++; if (current_floor !== 2'd1) begin errors++; $display("FAIL short_floor got %0d exp 1", current_floor); end
    $display("test_short_command done");
  endtask

  // DOWN at floor 1: one limit pulse after the first sampling edge, then quiet.
  task automatic test_bottom_limit();
    do_reset();
    elevator_direction = 2'b10;
    step();
    checks++; if (limit_err !== 1'b1) begin errors++; $display("FAIL bottom_limit got %b exp 1", limit_err); end
    step();
    checks++; if (limit_err !== 1'b0) begin errors++; $display("FAIL bottom_limit_once got %b exp 0", limit_err); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL bottom_moving got %b exp 0", moving); end
    elevator_direction = 2'b00;
    step();
    $display("test_bottom_limit done");
  endtask

  // Door opens in MOVE cycle 4 (edge 6): fault after edge 7, sticky until rst.
  task automatic test_door_fault();
    do_reset();
    elevator_direction = 2'b01;
    for (int k = 1; k <= 6; k++) step();
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL door_premove got %b exp 1", moving); end
    door_open = 1'b1;
    step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL door_fault got %b exp 1", fault); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL door_moving got %b exp 0", moving); end
    door_open = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL door_sticky k=%0d got %b exp 1", k, fault); end
      checks++; if (elevator_arrived !== 1'b0) begin errors++; $display("FAIL door_arrived k=%0d got %b exp 0", k, elevator_arrived); end
    end
    checks++; if (current_floor !== 2'd1) begin errors++; $display("FAIL door_floor got %0d exp 1", current_floor); end
    do_reset();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL door_reset_fault got %b exp 0", fault); end
    checks++; if (current_floor !== 2'd1) begin errors++; $display("FAIL door_reset_floor got %0d exp 1", current_floor); end
    $display("test_door_fault done");
  endtask

  // From floor 2: DOWN, reversed to UP at MOVE cycle 3; trip still ends at floor 1.
  task automatic test_reversal();
    do_reset();
    elevator_direction = 2'b01;
    for (int k = 1; k <= 11; k++) step();
    elevator_direction = 2'b00;
    step();
    checks++; if (current_floor !== 2'd2) begin errors++; $display("FAIL rev_setup_floor got %0d exp 2", current_floor); end
    elevator_direction = 2'b10;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 5) elevator_direction = 2'b01;
      if (k >= 6 && k <= 10) begin
        checks++; if (moving !== 1'b1) begin errors++; $display("FAIL rev_moving k=%0d got %b exp 1", k, moving); end
      end
    end
    checks++; if (elevator_arrived !== 1'b1) begin errors++; $display("FAIL rev_arrived got %b exp 1", elevator_arrived); end
    checks++; if (current_floor !== 2'd1) begin errors++; $display("FAIL rev_floor got %0d exp 1", current_floor); end
    elevator_direction = 2'b00;
    step();
    elevator_direction = 2'b11;
    step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL illegal_fault got %b exp 1", fault); end
    checks++; if (current_floor !== 2'd1) begin errors++; $display("FAIL illegal_floor got %0d exp 1", current_floor); end
    $display("test_reversal done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    elevator_direction = 2'b00;
    door_open = 1'b0;
    test_reset();
    test_single_trip();
    test_back_to_back();
    test_short_command();
    test_bottom_limit();
    test_door_fault();
    test_reversal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
